// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//   Single-clock FIFO pointer controller. Owns the binary read/write pointers
//   (AW+1 bits, MSB is the wrap bit), drives the storage RAM addresses and
//   write strobe, and produces full/empty/almost flags, occupancy count and
//   registered overflow/underflow pulses. Pointers are also exported
//   gray-coded so a later dual-clock synchroniser can reuse this controller.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   wr_en, rd_en      producer / consumer requests
//   ram_we            RAM write strobe (write accepted this cycle)
//   wr_addr, rd_addr  RAM addresses (RAM has synchronous read)
//   rd_valid          RAM read data valid, one cycle after an accepted read
//   full, empty       no free entry / no stored entry
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   count             occupancy 0..2**AW
//   wr_ptr_gray       gray-coded write pointer
//   rd_ptr_gray       gray-coded read pointer
//   overflow          one-cycle pulse: write requested while full
//   underflow         one-cycle pulse: read requested while empty
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl #(
  parameter int AW       = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          ram_we,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic [AW:0]   wr_ptr_gray,
  output logic [AW:0]   rd_ptr_gray,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] AF_THRESH = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_THRESH = (AW+1)'(AE_LEVEL);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        rd_valid_q;
  logic        overflow_q;
  logic        underflow_q;
  logic        wr_acc;
  logic        rd_acc;

  // Flags are derived from the registered pointers only, so an accepted
  // operation is reflected in full/empty/count on the following cycle.
  assign wr_ptr_gray = bin2gray(wr_ptr_q);
  assign rd_ptr_gray = bin2gray(rd_ptr_q);

  assign empty = (wr_ptr_gray == rd_ptr_gray);
  // In gray code, "one full lap apart" means the top two bits differ and
  // the remaining bits match.
  assign full  = (wr_ptr_gray == {~rd_ptr_gray[AW:AW-1], rd_ptr_gray[AW-2:0]});

  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_THRESH);
  assign almost_empty = (count <= AE_THRESH);

  // The strobe is suppressed while reset is held so a pending wr_en cannot
  // corrupt RAM during reset.
  assign wr_acc = wr_en & ~full & ~rst;
  assign rd_acc = rd_en & ~empty & ~rst;

  assign ram_we  = wr_acc;
  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_acc);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= wr_en & full;
      underflow_q <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
//   Self-checking bench for fifo_ptr_ctrl (AW=4). A queue-based reference
//   model tracks stored entries and total accepted writes/reads; every cycle
//   all DUT outputs are compared against values derived from that model.
// -----------------------------------------------------------------------------
module tb_fifo_ptr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic          ram_we;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic          overflow;
  logic          underflow;

  fifo_ptr_ctrl #(.AW(AW), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_we       (ram_we),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_ptr_gray  (rd_ptr_gray),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of RAM addresses holding data, plus lifetime
  // totals of accepted writes and reads.
  int q[$];
  int wtot, rtot;
  bit exp_rv, exp_ovf, exp_unf;

  function automatic int gray5(input int b);
    int m;
    m = b % 32;
    return m ^ (m / 2);
  endfunction

  task automatic model_reset();
    q.delete();
    wtot = 0;
    rtot = 0;
    exp_rv = 0;
    exp_ovf = 0;
    exp_unf = 0;
  endtask

  // Apply one cycle of requests: check outputs mid-cycle, then advance model.
  task automatic step(input bit w, input bit r);
    int  occ;
    bit  wacc, racc;
    logic [AW:0] prev_wg;
    wr_en = w;
    rd_en = r;
    @(negedge clk);
    occ  = q.size();
    wacc = w && (occ < DEPTH);
    racc = r && (occ > 0);
    check("ram_we",       int'(ram_we),       int'(wacc));
    check("wr_addr",      int'(wr_addr),      wtot % DEPTH);
    check("rd_addr",      int'(rd_addr),      (occ > 0) ? q[0] : (rtot % DEPTH));
    check("count",        int'(count),        occ);
    check("full",         int'(full),         int'(occ == DEPTH));
    check("empty",        int'(empty),        int'(occ == 0));
    check("almost_full",  int'(almost_full),  int'(occ >= 14));
    check("almost_empty", int'(almost_empty), int'(occ <= 2));
    check("wr_ptr_gray",  int'(wr_ptr_gray),  gray5(wtot));
    check("rd_ptr_gray",  int'(rd_ptr_gray),  gray5(rtot));
    check("rd_valid",     int'(rd_valid),     int'(exp_rv));
    check("overflow",     int'(overflow),     int'(exp_ovf));
    check("underflow",    int'(underflow),    int'(exp_unf));
    prev_wg = wr_ptr_gray;
    @(posedge clk);
    #1;
    exp_rv  = racc;
    exp_ovf = w && (occ == DEPTH);
    exp_unf = r && (occ == 0);
    if (racc) begin
      void'(q.pop_front());
      rtot++;
    end
    if (wacc) begin
      q.push_back(wtot % DEPTH);
      wtot++;
      check("gray_1bit", $countones(prev_wg ^ wr_ptr_gray), 1);
    end
  endtask

  initial begin
    int pw, pr;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    model_reset();
    #12;
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full),  0);
    check("rst_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Mid-stream reset with a read in flight and wr_en held high.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_empty",   int'(empty),        1);
    check("midrst_full",    int'(full),         0);
    check("midrst_count",   int'(count),        0);
    check("midrst_rdvalid", int'(rd_valid),     0);
    check("midrst_wgray",   int'(wr_ptr_gray),  0);
    check("midrst_rgray",   int'(rd_ptr_gray),  0);
    check("midrst_ramwe",   int'(ram_we),       0);
    check("midrst_ae",      int'(almost_empty), 1);
    check("midrst_af",      int'(almost_full),  0);
    model_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, then one rejected write.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
    // Drain to empty, then one rejected read.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Simultaneous requests at count 5, then at full and at empty.
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1);

    // Wrap: 40 writes interleaved with reads, crossing pointer value 31->0.
    for (int i = 0; i < 40; i++) step(1'b1, (i % 3) != 0);

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 10000; i++) begin
      case ((i / 500) % 3)
        0:       begin pw = 70; pr = 30; end
        1:       begin pw = 30; pr = 70; end
        default: begin pw = 50; pr = 50; end
      endcase
      step(($urandom % 100) < pw, ($urandom % 100) < pr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
